// File: rtl/full_adder.sv
// One-bit full adder cell; the serial adder reuses it once per operand bit.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell processes one bit per clock, LSB
// first, with a start/busy/done handshake and a registered result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] s_sh_r;
  logic             c_ff_r;
  logic [CNT_W-1:0] cnt_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             last_bit_s;
  logic [WIDTH-2:0] s_next_s;

  full_adder u_full_adder (
    .A     (a_sh_r[0]),
    .B     (b_sh_r[0]),
    .Cin   (c_ff_r),
    .Sum   (fa_sum_s),
    .Carry (fa_carry_s)
  );

  assign last_bit_s = (state_r == ST_RUN) && (cnt_r == LAST_CNT);
  // Partial-sum register keeps only the low WIDTH-1 bits; the final bit comes straight from the cell.
  assign s_next_s   = (WIDTH-1)'({fa_sum_s, s_sh_r} >> 1);
  assign busy       = state_r;

  // Sequencer: operand capture, bit shifting, carry flip-flop and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      s_sh_r  <= {(WIDTH-1){1'b0}};
      c_ff_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= A;
            b_sh_r  <= B;
            c_ff_r  <= Cin;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          s_sh_r <= s_next_s;
          c_ff_r <= fa_carry_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output stage: result and done pulse update only on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum  <= {WIDTH{1'b0}};
      Cout <= 1'b0;
      done <= 1'b0;
    end else if (last_bit_s) begin
      Sum  <= {fa_sum_s, s_sh_r};
      Cout <= fa_carry_s;
      done <= 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

endmodule
